// File: rtl/mem_bus_arbiter.sv
// Arbitrates the core's fetch and data buses onto one downstream memory port.
// Data has priority; a streak limiter forces a fetch grant after MAX_D_STREAK contended data grants.
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_data_ok,
  input  logic [63:0] m_rdata,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  // Handshake: a requester raises x_valid and holds it with stable fields until
  // x_data_ok; downstream, m_valid and m_* stay constant until m_data_ok.
  logic [1:0] state;
  logic [3:0] streak;
  logic       grant_d;
  logic       grant_i;

  always_comb begin
    grant_d = d_valid && (!i_valid || (streak < STREAK_MAX));
    grant_i = i_valid && !grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      streak   <= 4'd0;
      m_valid  <= 1'b0;
      m_addr   <= 64'd0;
      m_size   <= 3'd0;
      m_strobe <= 8'd0;
      m_wdata  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= BUSY_D;
            m_valid  <= 1'b1;
            m_addr   <= d_addr;
            m_size   <= d_size;
            m_strobe <= d_strobe;
            m_wdata  <= d_wdata;
            // The streak only grows while a fetch is actually waiting.
            streak   <= i_valid ? (streak + 4'd1) : 4'd0;
          end else if (grant_i) begin
            state    <= BUSY_I;
            m_valid  <= 1'b1;
            m_addr   <= i_addr;
            m_size   <= 3'b010;
            m_strobe <= 8'd0;
            m_wdata  <= 64'd0;
            streak   <= 4'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_data_ok) begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  // Completion is passed through combinationally; an owner that dropped valid gets no pulse.
  always_comb begin
    i_data_ok = (state == BUSY_I) && m_data_ok && i_valid;
    d_data_ok = (state == BUSY_D) && m_data_ok && d_valid;
    i_data    = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
    d_rdata   = m_rdata;
    fsm_state = state;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single downstream memory port between the core's instruction fetch bus and data bus.
- Sits between the pipeline core (fetch stage requests and memory stage requests) and the memory/cache interface.
- Latches the granted request and holds it stable downstream until completion, then routes the response back to the owner.
- Fixed data-first priority, with a starvation limiter that guarantees fetch progress.

Parameters:
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch request is pending; the next grant goes to fetch. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_valid  in  1  fetch request valid; held until i_data_ok.
- i_addr  in  64  fetch address.
- i_data_ok  out  1  single-cycle fetch completion pulse.
- i_data  out  32  fetch data, valid when i_data_ok=1.
- d_valid  in  1  data request valid; held until d_data_ok.
- d_addr  in  64  data address.
- d_size  in  3  access size (log2 bytes).
- d_strobe  in  8  byte write strobes; all zero means read.
- d_wdata  in  64  store data.
- d_data_ok  out  1  single-cycle data completion pulse.
- d_rdata  out  64  load data, valid when d_data_ok=1.
- m_valid  out  1  downstream request valid, registered.
- m_addr  out  64  latched address.
- m_size  out  3  latched size; 3'b010 for fetch.
- m_strobe  out  8  latched strobes; 0 for fetch.
- m_wdata  out  64  latched store data; 0 for fetch.
- m_data_ok  in  1  downstream completion pulse.
- m_rdata  in  64  downstream read data.

Behaviour:
- Reset: state=IDLE; m_valid=0; m_addr, m_size, m_strobe, m_wdata=0; streak counter=0; i_data_ok=0; d_data_ok=0.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- Arbitration (IDLE only), evaluated each cycle on the current request inputs:
  - d_valid and i_valid, streak<MAX_D_STREAK -> grant D, streak+1.
  - d_valid and i_valid, streak==MAX_D_STREAK -> grant I, streak=0.
  - d_valid only -> grant D, streak=0.
  - i_valid only -> grant I, streak=0.
  - No request -> stay in IDLE.
- On grant: latch the request fields into the m_* registers, set m_valid=1 at the same edge, and move to BUSY_x.
  - Request seen in cycle N -> m_valid=1 in cycle N+1.
- BUSY_x: m_valid and all m_* fields stay constant until m_data_ok=1.
  - In the m_data_ok cycle, x_data_ok=1 (combinational passthrough).
  - i_data = m_rdata[31:0] when addr[2]=0, else m_rdata[63:32]. d_rdata = m_rdata unchanged.
  - At the following edge: m_valid=0, state=IDLE.
  - Minimum spacing between grants is 2 cycles (one IDLE cycle between transactions).
- The non-owner's data_ok is always 0. Data outputs are don't-care when the matching ok is 0; the bench checks them only with ok=1.
- m_data_ok while in IDLE: ignored, no ok pulse generated.
- Owner drops valid mid-transaction: the downstream transaction still completes; the ok pulse is suppressed if the owner's valid=0 in the completion cycle.
- Simultaneous m_data_ok and a new request: completion is handled first; the new request is arbitrated in the next IDLE cycle.
- Reset asserted mid-transaction: immediate return to reset values; the outstanding downstream response after release is ignored (IDLE rule).

Test Plan:
- Single fetch: i_valid=1, i_addr=0x8000_0004, m_data_ok on the 3rd cycle after m_valid with m_rdata=0x1111_2222_3333_4444 -> m_addr=0x8000_0004, m_size=2, i_data_ok 1 cycle, i_data=0x1111_2222; m_valid=0 the next cycle.
- Single store: d_valid=1, d_addr=0x8000_1000, d_strobe=0xFF, d_wdata=0xDEAD_BEEF -> m_* latched with the same values; d_data_ok pulses with m_data_ok; i_data_ok stays 0.
- Contention and starvation: i_valid and d_valid held high continuously, MAX_D_STREAK=4, 1-cycle memory -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Stability: change d_addr while in BUSY_D -> m_addr is unchanged until completion.
- Abandon: drop i_valid in BUSY_I before m_data_ok -> m_valid remains 1 until m_data_ok; no i_data_ok; back to IDLE.
- Async reset: assert reset=0 mid BUSY_D, between edges -> m_valid=0 immediately; after release a stray m_data_ok produces no ok pulse.
